// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour-index width and the power-up palette.
package vga_pkg;

   localparam int unsigned DEF_H_VIS  = 640;
   localparam int unsigned DEF_H_FP   = 16;
   localparam int unsigned DEF_H_SYNC = 96;
   localparam int unsigned DEF_H_BP   = 48;
   localparam int unsigned DEF_V_VIS  = 480;
   localparam int unsigned DEF_V_FP   = 10;
   localparam int unsigned DEF_V_SYNC = 2;
   localparam int unsigned DEF_V_BP   = 33;
   localparam bit          DEF_HS_POL = 1'b0;
   localparam bit          DEF_VS_POL = 1'b0;
   localparam int unsigned DEF_IDX_W  = 3;
   localparam int unsigned DEF_CH_W   = 8;

   localparam logic [23:0] PAL_BLACK   = 24'h000000;
   localparam logic [23:0] PAL_BLUE    = 24'h0000FF;
   localparam logic [23:0] PAL_BROWN   = 24'hA52A2A;
   localparam logic [23:0] PAL_CYAN    = 24'h008B8B;
   localparam logic [23:0] PAL_RED     = 24'hFF0000;
   localparam logic [23:0] PAL_MAGENTA = 24'h8B008B;
   localparam logic [23:0] PAL_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] PAL_WHITE   = 24'hFFFFFF;

   // Reset colour of a palette slot as 8-bit {R,G,B}; slots past 7 are black.
   function automatic logic [23:0] default_rgb(int unsigned idx);
      case (idx)
         0:       return PAL_BLACK;
         1:       return PAL_BLUE;
         2:       return PAL_BROWN;
         3:       return PAL_CYAN;
         4:       return PAL_RED;
         5:       return PAL_MAGENTA;
         6:       return PAL_YELLOW;
         7:       return PAL_WHITE;
         default: return 24'h000000;
      endcase
   endfunction

endpackage

// File: rtl/vga_palette.sv
// Colour palette: flop storage with async reset to defaults, one write port
// (independent of the pixel enable) and a combinational read port.
module vga_palette
   import vga_pkg::*;
#(
   parameter int unsigned IDX_W = DEF_IDX_W,
   parameter int unsigned CH_W  = DEF_CH_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IDX_W-1:0]    waddr,
   input  logic [3*CH_W-1:0]   wdata,
   input  logic [IDX_W-1:0]    raddr,
   output logic [3*CH_W-1:0]   rdata_c
);

   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam int unsigned DW    = 3 * CH_W;

   logic [DW-1:0] mem_q [DEPTH];

   // Resize each 8-bit default channel to the configured channel width.
   function automatic logic [DW-1:0] reset_entry(int unsigned i);
      logic [23:0] c;
      c = default_rgb(i);
      return {CH_W'(c[23:16]), CH_W'(c[15:8]), CH_W'(c[7:0])};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[IDX_W'(i)] <= reset_entry(i);
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Sampled by the caller's register, so a same-edge write is not yet visible.
   assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with a two-stage palette pipeline; all state
// except the palette advances only on enabled pixel cycles.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_VIS  = DEF_H_VIS,
   parameter int unsigned H_FP   = DEF_H_FP,
   parameter int unsigned H_SYNC = DEF_H_SYNC,
   parameter int unsigned H_BP   = DEF_H_BP,
   parameter int unsigned V_VIS  = DEF_V_VIS,
   parameter int unsigned V_FP   = DEF_V_FP,
   parameter int unsigned V_SYNC = DEF_V_SYNC,
   parameter int unsigned V_BP   = DEF_V_BP,
   parameter bit          HS_POL = DEF_HS_POL,
   parameter bit          VS_POL = DEF_VS_POL,
   parameter int unsigned IDX_W  = DEF_IDX_W,
   parameter int unsigned CH_W   = DEF_CH_W,
   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP,
   localparam int unsigned HW      = $clog2(H_TOTAL),
   localparam int unsigned VW      = $clog2(V_TOTAL)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [IDX_W-1:0]  color_idx,
   input  logic              pal_we,
   input  logic [IDX_W-1:0]  pal_addr,
   input  logic [3*CH_W-1:0] pal_data,
   output logic [HW-1:0]     px,
   output logic [VW-1:0]     py,
   output logic [CH_W-1:0]   R,
   output logic [CH_W-1:0]   G,
   output logic [CH_W-1:0]   B,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              frame_start
);

   localparam int unsigned DW = 3 * CH_W;

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
   localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
   localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC - 1);

   logic [HW-1:0]    h_cnt_q, h_cnt_d;
   logic [VW-1:0]    v_cnt_q, v_cnt_d;

   logic             visible_c, hsync_c, vsync_c, frame_c;

   logic [IDX_W-1:0] idx1_q;
   logic             vis1_q, hs1_q, vs1_q, fs1_q;

   logic [DW-1:0]    rgb_q, rgb_d;
   logic             de_q, hs_q, vs_q, fs_q;

   logic [DW-1:0]    pal_rd_c;

   // Raster counters: line wrap carries into the frame counter.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (en) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign px = h_cnt_q;
   assign py = v_cnt_q;

   // Position decode for the pixel currently addressed by the counters.
   always_comb begin
      visible_c = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
      hsync_c   = ((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END)) ? HS_POL : ~HS_POL;
      vsync_c   = ((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END)) ? VS_POL : ~VS_POL;
      frame_c   = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   // Stage 1: capture the pixel index alongside its control decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx1_q <= '0;
         vis1_q <= 1'b0;
         hs1_q  <= ~HS_POL;
         vs1_q  <= ~VS_POL;
         fs1_q  <= 1'b0;
      end else if (en) begin
         idx1_q <= color_idx;
         vis1_q <= visible_c;
         hs1_q  <= hsync_c;
         vs1_q  <= vsync_c;
         fs1_q  <= frame_c;
      end
   end

   vga_palette #(
      .IDX_W (IDX_W),
      .CH_W  (CH_W)
   ) u_palette (
      .clk     (clk),
      .rst     (rst),
      .we      (pal_we),
      .waddr   (pal_addr),
      .wdata   (pal_data),
      .raddr   (idx1_q),
      .rdata_c (pal_rd_c)
   );

   // Blanked pixels are forced black regardless of the index supplied.
   assign rgb_d = vis1_q ? pal_rd_c : '0;

   // Stage 2: palette result and delayed controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q <= '0;
         de_q  <= 1'b0;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         fs_q  <= 1'b0;
      end else if (en) begin
         rgb_q <= rgb_d;
         de_q  <= vis1_q;
         hs_q  <= hs1_q;
         vs_q  <= vs1_q;
         fs_q  <= fs1_q;
      end
   end

   assign R           = rgb_q[DW-1 -: CH_W];
   assign G           = rgb_q[2*CH_W-1 -: CH_W];
   assign B           = rgb_q[CH_W-1:0];
   assign de          = de_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default 640x480 instance for line/pixel/palette behaviour,
// tiny 8x5 instance for whole-frame timing.
module tb_vga_timing_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [2:0]  color_idx;
   logic        pal_we;
   logic [2:0]  pal_addr;
   logic [23:0] pal_data;

   logic [9:0]  d_px, d_py;
   logic [7:0]  d_r, d_g, d_b;
   logic        d_hs, d_vs, d_de, d_fs;

   logic [2:0]  s_px, s_py;
   logic [7:0]  s_r, s_g, s_b;
   logic        s_hs, s_vs, s_de, s_fs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vga_timing_ctrl u_dflt (
      .clk(clk), .rst(rst), .en(en), .color_idx(color_idx),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .px(d_px), .py(d_py), .R(d_r), .G(d_g), .B(d_b),
      .hsync(d_hs), .vsync(d_vs), .de(d_de), .frame_start(d_fs)
   );

   vga_timing_ctrl #(
      .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
   ) u_small (
      .clk(clk), .rst(rst), .en(en), .color_idx(color_idx),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .px(s_px), .py(s_py), .R(s_r), .G(s_g), .B(s_b),
      .hsync(s_hs), .vsync(s_vs), .de(s_de), .frame_start(s_fs)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at a falling edge with counters at 0,0 and no edge taken yet.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b1; color_idx = 3'd7;
      do_reset();
      step(20);
      rst = 1'b1;
      #1;
      n_cmp++; if (d_px !== 10'd0) begin n_bad++; $display("FAIL reset_px: got %0d want 0", d_px); end
      n_cmp++; if (d_py !== 10'd0) begin n_bad++; $display("FAIL reset_py: got %0d want 0", d_py); end
      n_cmp++; if ({d_r, d_g, d_b} !== 24'h0) begin n_bad++; $display("FAIL reset_rgb: got %h want 000000", {d_r, d_g, d_b}); end
      n_cmp++; if ({d_de, d_fs} !== 2'b00) begin n_bad++; $display("FAIL reset_de_fs: got %b want 00", {d_de, d_fs}); end
      n_cmp++; if ({d_hs, d_vs} !== 2'b11) begin n_bad++; $display("FAIL reset_sync_dflt: got %b want 11", {d_hs, d_vs}); end
      n_cmp++; if ({s_hs, s_vs} !== 2'b01) begin n_bad++; $display("FAIL reset_sync_small: got %b want 01", {s_hs, s_vs}); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_first_frame();
      en = 1'b1; color_idx = 3'd7;
      do_reset();
      n_cmp++; if ({d_px, d_fs} !== {10'd0, 1'b0}) begin n_bad++; $display("FAIL first_s0: got px=%0d fs=%b want px=0 fs=0", d_px, d_fs); end
      step(1);
      n_cmp++; if ({d_px, d_fs} !== {10'd1, 1'b0}) begin n_bad++; $display("FAIL first_s1: got px=%0d fs=%b want px=1 fs=0", d_px, d_fs); end
      step(1);
      n_cmp++; if ({d_fs, d_de} !== 2'b11) begin n_bad++; $display("FAIL first_s2_fs_de: got %b want 11", {d_fs, d_de}); end
      n_cmp++; if ({d_r, d_g, d_b} !== 24'hFFFFFF) begin n_bad++; $display("FAIL first_s2_rgb: got %h want ffffff", {d_r, d_g, d_b}); end
      step(1);
      n_cmp++; if (d_fs !== 1'b0) begin n_bad++; $display("FAIL first_s3_fs: got %b want 0", d_fs); end
   endtask

   // One 800-cycle line on the default instance with index 7 held.
   task automatic test_hline();
      int first_low = -1;
      int lows = 0;
      int extra_fs = 0;
      logic [9:0] px639 = '0;
      logic [24:0] s641 = '0, s642 = '0;
      logic [19:0] wrap = '0;
      en = 1'b1; color_idx = 3'd7;
      do_reset();
      for (int n = 1; n <= 802; n++) begin
         @(negedge clk);
         if (d_hs === 1'b0) begin
            lows++;
            if (first_low < 0) first_low = n;
         end
         if (n >= 3 && d_fs === 1'b1) extra_fs++;
         if (n == 639) px639 = d_px;
         if (n == 641) s641 = {d_de, d_r, d_g, d_b};
         if (n == 642) s642 = {d_de, d_r, d_g, d_b};
         if (n == 800) wrap = {d_px, d_py};
      end
      n_cmp++; if (first_low != 658) begin n_bad++; $display("FAIL hsync_start: got %0d want 658", first_low); end
      n_cmp++; if (lows != 96) begin n_bad++; $display("FAIL hsync_width: got %0d want 96", lows); end
      n_cmp++; if (px639 !== 10'd639) begin n_bad++; $display("FAIL px_639: got %0d want 639", px639); end
      n_cmp++; if (s641 !== {1'b1, 24'hFFFFFF}) begin n_bad++; $display("FAIL pix_639: got %h want 1ffffff", s641); end
      n_cmp++; if (s642 !== 25'h0) begin n_bad++; $display("FAIL pix_640: got %h want 0000000", s642); end
      n_cmp++; if (wrap !== {10'd0, 10'd1}) begin n_bad++; $display("FAIL line_wrap: got %h want 00001", wrap); end
      n_cmp++; if (extra_fs != 0) begin n_bad++; $display("FAIL fs_spurious: got %0d want 0", extra_fs); end
   endtask

   task automatic test_palette_rbw();
      en = 1'b1; color_idx = 3'd1; pal_we = 1'b0;
      do_reset();
      step(1);
      pal_we = 1'b1; pal_addr = 3'd1; pal_data = 24'h123456;
      step(1);
      pal_we = 1'b0;
      n_cmp++; if ({d_r, d_g, d_b} !== 24'h0000FF) begin n_bad++; $display("FAIL rbw_old: got %h want 0000ff", {d_r, d_g, d_b}); end
      step(1);
      n_cmp++; if ({d_r, d_g, d_b} !== 24'h123456) begin n_bad++; $display("FAIL rbw_new: got %h want 123456", {d_r, d_g, d_b}); end
      en = 1'b0; pal_we = 1'b1; pal_data = 24'hABCDEF;
      step(1);
      pal_we = 1'b0;
      n_cmp++; if ({d_px, d_r, d_g, d_b} !== {10'd3, 24'h123456}) begin n_bad++; $display("FAIL wr_en0_hold: got %h want 3123456", {d_px, d_r, d_g, d_b}); end
      en = 1'b1;
      step(1);
      n_cmp++; if ({d_r, d_g, d_b} !== 24'hABCDEF) begin n_bad++; $display("FAIL wr_en0_data: got %h want abcdef", {d_r, d_g, d_b}); end
   endtask

   task automatic test_en_hold();
      en = 1'b1; color_idx = 3'd3;
      do_reset();
      step(5);
      n_cmp++; if ({d_px, d_de, d_r, d_g, d_b} !== {10'd5, 1'b1, 24'h008B8B}) begin n_bad++; $display("FAIL hold_pre: got %h want 0b008b8b", {d_px, d_de, d_r, d_g, d_b}); end
      en = 1'b0; color_idx = 3'd4;
      step(3);
      n_cmp++; if ({d_px, d_de, d_hs, d_r, d_g, d_b} !== {10'd5, 1'b1, 1'b1, 24'h008B8B}) begin n_bad++; $display("FAIL hold_en0: got %h want 17008b8b", {d_px, d_de, d_hs, d_r, d_g, d_b}); end
      en = 1'b1;
      step(1);
      n_cmp++; if ({d_r, d_g, d_b} !== 24'h008B8B) begin n_bad++; $display("FAIL hold_resume1: got %h want 008b8b", {d_r, d_g, d_b}); end
      step(1);
      n_cmp++; if ({d_r, d_g, d_b} !== 24'hFF0000) begin n_bad++; $display("FAIL hold_resume2: got %h want ff0000", {d_r, d_g, d_b}); end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; color_idx = 3'd7;
      do_reset();
      pal_we = 1'b1; pal_addr = 3'd7; pal_data = 24'h111111;
      step(1);
      pal_we = 1'b0;
      step(299);
      n_cmp++; if ({d_px, d_r, d_g, d_b} !== {10'd300, 24'h111111}) begin n_bad++; $display("FAIL mid_pre: got %h want 12c111111", {d_px, d_r, d_g, d_b}); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({d_px, d_py, d_de, d_hs, d_r, d_g, d_b} !== {20'd0, 1'b0, 1'b1, 24'h0}) begin n_bad++; $display("FAIL mid_async: got %h want 0001000000", {d_px, d_py, d_de, d_hs, d_r, d_g, d_b}); end
      @(negedge clk);
      rst = 1'b0;
      step(2);
      n_cmp++; if ({d_px, d_py, d_fs} !== {10'd2, 10'd0, 1'b1}) begin n_bad++; $display("FAIL mid_restart: got px=%0d py=%0d fs=%b want 2 0 1", d_px, d_py, d_fs); end
      n_cmp++; if ({d_r, d_g, d_b} !== 24'hFFFFFF) begin n_bad++; $display("FAIL mid_pal_default: got %h want ffffff", {d_r, d_g, d_b}); end
   endtask

   // Whole frames on the 8x5 instance.
   task automatic test_small_frame();
      int fs_pos [2] = '{-1, -1};
      int nfs = 0;
      int hs_hi = 0, hs_first = -1, vs_lo = 0, vs_first = -1, de_cnt = 0, de_line2 = 0;
      logic prev = 1'b0;
      logic [5:0] wrap = '0;
      en = 1'b1; color_idx = 3'd7;
      do_reset();
      for (int n = 1; n <= 90; n++) begin
         @(negedge clk);
         if (s_fs === 1'b1 && prev === 1'b0 && nfs < 2) begin fs_pos[nfs] = n; nfs++; end
         prev = s_fs;
         if (n >= 2 && n <= 41) begin
            if (s_hs === 1'b1) begin hs_hi++; if (hs_first < 0) hs_first = n; end
            if (s_vs === 1'b0) begin vs_lo++; if (vs_first < 0) vs_first = n; end
            if (s_de === 1'b1) de_cnt++;
            if (n >= 18 && n <= 25 && (s_de !== 1'b0 || {s_r, s_g, s_b} !== 24'h0)) de_line2++;
         end
         if (n == 8) wrap = {s_px, s_py};
      end
      n_cmp++; if (fs_pos[0] != 2) begin n_bad++; $display("FAIL small_fs_first: got %0d want 2", fs_pos[0]); end
      n_cmp++; if (fs_pos[1] - fs_pos[0] != 40) begin n_bad++; $display("FAIL small_frame_period: got %0d want 40", fs_pos[1] - fs_pos[0]); end
      n_cmp++; if (hs_first != 7) begin n_bad++; $display("FAIL small_hs_first: got %0d want 7", hs_first); end
      n_cmp++; if (hs_hi != 10) begin n_bad++; $display("FAIL small_hs_count: got %0d want 10", hs_hi); end
      n_cmp++; if (vs_first != 26) begin n_bad++; $display("FAIL small_vs_first: got %0d want 26", vs_first); end
      n_cmp++; if (vs_lo != 8) begin n_bad++; $display("FAIL small_vs_count: got %0d want 8", vs_lo); end
      n_cmp++; if (de_cnt != 8) begin n_bad++; $display("FAIL small_de_count: got %0d want 8", de_cnt); end
      n_cmp++; if (de_line2 != 0) begin n_bad++; $display("FAIL small_line2_blank: got %0d want 0", de_line2); end
      n_cmp++; if (wrap !== {3'd0, 3'd1}) begin n_bad++; $display("FAIL small_wrap: got %o want 01", wrap); end
   endtask

   // en alternating 1/0 every clock doubles the frame period in clocks.
   task automatic test_en_toggle();
      int fs_pos [2] = '{-1, -1};
      int nfs = 0;
      logic prev = 1'b0;
      en = 1'b1; color_idx = 3'd7;
      do_reset();
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         en = ~en;
         if (s_fs === 1'b1 && prev === 1'b0 && nfs < 2) begin fs_pos[nfs] = c; nfs++; end
         prev = s_fs;
      end
      en = 1'b1;
      n_cmp++; if (fs_pos[0] != 3) begin n_bad++; $display("FAIL toggle_fs_first: got %0d want 3", fs_pos[0]); end
      n_cmp++; if (fs_pos[1] - fs_pos[0] != 80) begin n_bad++; $display("FAIL toggle_period: got %0d want 80", fs_pos[1] - fs_pos[0]); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; color_idx = '0;
      pal_we = 1'b0; pal_addr = '0; pal_data = '0;
      test_reset();
      test_first_frame();
      test_hline();
      test_palette_rbw();
      test_en_hold();
      test_reset_mid();
      test_small_frame();
      test_en_toggle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  H_VIS 640, visible pixels per line
  H_FP 16, horizontal front porch
  H_SYNC 96, hsync width
  H_BP 48, horizontal back porch
  V_VIS 480, visible lines
  V_FP 10, vertical front porch
  V_SYNC 2, vsync width
  V_BP 33, vertical back porch
  HS_POL 0, hsync active level
  VS_POL 0, vsync active level
  IDX_W 3, colour index width
  CH_W 8, bits per colour channel
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk in 1, the single clock
  rst in 1, asynchronous active-high reset
  en in 1, pixel-clock enable; all state advances only when en=1
  color_idx in IDX_W, palette index for pixel (px,py) in the current cycle
  pal_we in 1, palette write strobe
  pal_addr in IDX_W, palette write address
  pal_data in 3*CH_W, {R,G,B} write data
  px out clog2(H_TOTAL), current horizontal count
  py out clog2(V_TOTAL), current vertical count
  R/G/B out CH_W each, registered pixel colour
  hsync out 1, horizontal sync
  vsync out 1, vertical sync
  de out 1, display enable aligned with RGB
  frame_start out 1, one-enabled-cycle pulse aligned with first visible pixel of a frame

Function
REQ-003 H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP and V_TOTAL=V_VIS+V_FP+V_SYNC+V_BP (800/525 at defaults).
REQ-004 h_cnt increments on each enabled cycle, wraps from H_TOTAL-1 to 0; v_cnt increments on that wrap, wraps from V_TOTAL-1 to 0 when both counters are at their maxima.
REQ-005 px=h_cnt and py=v_cnt are driven directly from the counters (zero latency).
REQ-006 Visible when h_cnt<H_VIS and v_cnt<V_VIS (strict less-than; column 640 and line 480 are blanking).
REQ-007 hsync is active (=HS_POL) for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751 at defaults; inactive (=~HS_POL) otherwise.
REQ-008 vsync is active (=VS_POL) for v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491 at defaults; inactive otherwise.
REQ-009 Two-stage pipeline. Stage 1 registers color_idx, visible, hsync, vsync and frame flag. Stage 2 registers the palette lookup and the delayed controls. Latency from (px,py,color_idx) to R/G/B/de/hsync/vsync/frame_start is exactly 2 enabled cycles.
REQ-010 R=G=B=0 whenever de=0, regardless of color_idx.
REQ-011 frame_start=1 only on the output cycle corresponding to h_cnt=0, v_cnt=0.
REQ-012 Palette: 2**IDX_W entries of 3*CH_W bits. A write at an enabled or disabled clock edge with pal_we=1 stores pal_data at pal_addr.
REQ-013 A palette write is not gated by en.
REQ-014 A stage-2 lookup of the same entry in the same cycle as its write returns the old value (read-before-write); the new value is used from the next edge onward.
REQ-015 When en=0, counters, pipeline and outputs hold their values; palette writes still occur.
REQ-016 Default palette, entries 0..7: black 000000, blue 0000FF, brown A52A2A, cyan 008B8B, red FF0000, magenta 8B008B, yellow FFFF00, white FFFFFF.
REQ-017 Entries above 7, when IDX_W>3, default to 0.

Reset
REQ-018 rst asynchronously forces:
  h_cnt=v_cnt=0
  pipeline de=0, frame_start=0, R=G=B=0
  hsync=~HS_POL, vsync=~VS_POL
  all palette entries to the REQ-016/017 defaults
REQ-019 Reset asserted mid-frame aborts the frame.
REQ-020 After rst deasserts, the first enabled cycle presents px=0, py=0, and frame_start asserts 2 enabled cycles later.

Structure
REQ-021 Shared package vga_pkg holds the default timing constants, default palette constants and the colour-index width; no per-instance logic.
REQ-022 Palette storage plus its read-before-write port are one sub-module, vga_palette; counters, sync decode and the pipeline live in vga_timing_ctrl.

Verification
REQ-023 Defaults, en=1, full frame after reset:
  exactly 800x525 cycles between frame_start pulses
  hsync low for 96 cycles starting 658 cycles after line start (2-cycle latency)
  vsync low for 2 lines
REQ-024 Boundary: color_idx=7 held constant:
  RGB=FFFFFF at px=639
  RGB=000000, de=0 at px=640
  RGB=000000, de=0 on every pixel of py=480
REQ-025 Palette write pal_addr=1, pal_data=123456 while px=0 reads index 1:
  old 0000FF appears on the same-cycle lookup
  123456 appears from the next lookup onward
REQ-026 en toggling 1/0 every cycle:
  frame period doubles to 840000 clocks
  outputs stable during en=0 cycles
REQ-027 rst pulsed at px=300, py=200:
  all outputs take reset values immediately, before any clock edge
  counting restarts at 0,0 after release
  palette returns to defaults
REQ-028 Parameter set H_VIS=4, H_FP=1, H_SYNC=2, H_BP=1, V_VIS=2, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1: hsync high for h_cnt 5..6, 8-cycle lines, 5-line frames.
